spi_tx_mode: RTL and testbench

Parametrised SPI transmit serialiser; next generation of the single-mode byte transmitter. Adds selectable CPOL/CPHA, bit order and a valid/ready word interface with optional double buffering for gap-free back-to-back words. Sits between the DAQ command/config logic and the MOSI pin. Operates in the system clock domain against an SCLK_i generated by the SPI master logic that is synchronous to clock_i.

---
 rtl/spi_tx_mode.sv | 183 ++++++++++++++++++
 tb/tb_spi_tx_mode.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_mode.sv
// rtl/spi_tx_mode.sv - SPI transmit serialiser with CPOL/CPHA, bit order and valid/ready word input
// Optional holding register for gap-free back-to-back words: define SPI_TX_DOUBLE_BUFFER_EN.
// SCLK_i is sampled in the clock_i domain, so every MOSI_o, tx_done_o and underrun_o update
// lands one clock_i cycle after the SCLK_i level change that caused it.

module spi_tx_mode #(
   parameter int WIDTH     = 8,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             tx_en_i,
   input  logic             SCLK_i,
   input  logic             tx_valid_i,
   input  logic [WIDTH-1:0] tx_data_i,
   output logic             tx_ready_o,
   output logic             MOSI_o,
   output logic             tx_busy_o,
   output logic             tx_done_o,
   output logic             underrun_o
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_n;
   logic             sclk_q;
   logic             lead_edge;
   logic             trail_edge;
   logic             word_end;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_n;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] bit_cnt_n;
   logic             mosi_n;
   logic             done_n;
   logic             underrun_n;

   // Word source for the shift register: holding register or the input port
   logic             accept;
   logic             next_avail;
   logic [WIDTH-1:0] next_word;
   logic [WIDTH-1:0] next_ordered;

   // Edges only count while the frame is enabled; sclk_q keeps tracking regardless
   assign lead_edge  = tx_en_i && (sclk_q == CPOL) && (SCLK_i != CPOL);
   assign trail_edge = tx_en_i && (sclk_q != CPOL) && (SCLK_i == CPOL);
   assign word_end   = (state == S_ACTIVE) && trail_edge && (bit_cnt == LAST_CNT);
   assign tx_busy_o  = (state == S_ACTIVE);

   // Reorder the incoming word so the shift register always shifts out of its MSB
   for (genvar g = 0; g < WIDTH; g++) begin : g_order
      assign next_ordered[g] = MSB_FIRST ? next_word[g] : next_word[WIDTH-1-g];
   end

`ifdef SPI_TX_DOUBLE_BUFFER_EN
   logic             hold_valid;
   logic [WIDTH-1:0] hold_data;
   logic             shift_load;

   assign tx_ready_o = !hold_valid;
   assign accept     = tx_valid_i && !hold_valid;
   assign next_avail = hold_valid || accept;
   assign next_word  = hold_valid ? hold_data : tx_data_i;
   assign shift_load = next_avail && ((state == S_IDLE) || word_end);

   // Holding register: fills on an accept the shift register cannot take, drains on a load
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (hold_valid) begin
         if (shift_load) begin
            hold_valid <= 1'b0;
         end
      end else if (accept && !shift_load) begin
         hold_valid <= 1'b1;
         hold_data  <= tx_data_i;
      end
   end
`else
   assign tx_ready_o = (state == S_IDLE);
   assign accept     = tx_valid_i && (state == S_IDLE);
   assign next_avail = accept;
   assign next_word  = tx_data_i;
`endif

   // SCLK level history for edge detection
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sclk_q <= CPOL;
      end else begin
         sclk_q <= SCLK_i;
      end
   end

   // Next-state, shift, bit counter and output decisions
   always_comb begin
      state_n    = state;
      shift_n    = shift_q;
      bit_cnt_n  = bit_cnt;
      mosi_n     = MOSI_o;
      done_n     = 1'b0;
      underrun_n = 1'b0;

      case (state)
         S_IDLE: begin
            mosi_n     = 1'b0;
            underrun_n = lead_edge;
            if (next_avail) begin
               state_n   = S_ACTIVE;
               bit_cnt_n = '0;
               if (CPHA) begin
                  shift_n = next_ordered;
                  mosi_n  = 1'b0;
               end else begin
                  shift_n = next_ordered << 1;
                  mosi_n  = next_ordered[WIDTH-1];
               end
            end
         end

         default: begin
            if (!tx_en_i) begin
               // Abort: the current word is dropped without a done pulse
               state_n   = S_IDLE;
               bit_cnt_n = '0;
               mosi_n    = 1'b0;
            end else if (word_end) begin
               done_n    = 1'b1;
               bit_cnt_n = '0;
               if (next_avail) begin
                  if (CPHA) begin
                     shift_n = next_ordered;
                     mosi_n  = 1'b0;
                  end else begin
                     shift_n = next_ordered << 1;
                     mosi_n  = next_ordered[WIDTH-1];
                  end
               end else begin
                  state_n = S_IDLE;
                  mosi_n  = 1'b0;
               end
            end else if (trail_edge) begin
               bit_cnt_n = bit_cnt + 1'b1;
               if (!CPHA) begin
                  mosi_n  = shift_q[WIDTH-1];
                  shift_n = shift_q << 1;
               end
            end else if (lead_edge && CPHA) begin
               mosi_n  = shift_q[WIDTH-1];
               shift_n = shift_q << 1;
            end
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= S_IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         MOSI_o     <= 1'b0;
         tx_done_o  <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         state      <= state_n;
         shift_q    <= shift_n;
         bit_cnt    <= bit_cnt_n;
         MOSI_o     <= mosi_n;
         tx_done_o  <= done_n;
         underrun_o <= underrun_n;
      end
   end

endmodule

// File: tb/tb_spi_tx_mode.sv
// tb/tb_spi_tx_mode.sv - directed self-checking bench for spi_tx_mode

module tb_spi_tx_mode;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en0, sclk0, valid0;
   logic [7:0] data0;
   logic       ready0, mosi0, busy0, done0, under0;
   logic       en1, sclk1, valid1;
   logic [7:0] data1;
   logic       ready1, mosi1, busy1, done1, under1;

   int checks = 0;
   int errors = 0;
   int dc0 = 0;
   int uc0 = 0;
   int dc1 = 0;
   int uc1 = 0;
   int busy_low = 0;
   int base;
   logic mon = 1'b0;
   logic [7:0] w, w2;

   spi_tx_mode dut0 (
      .clock_i(clk), .reset_i(rst), .tx_en_i(en0), .SCLK_i(sclk0),
      .tx_valid_i(valid0), .tx_data_i(data0), .tx_ready_o(ready0),
      .MOSI_o(mosi0), .tx_busy_o(busy0), .tx_done_o(done0), .underrun_o(under0)
   );

   spi_tx_mode #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut1 (
      .clock_i(clk), .reset_i(rst), .tx_en_i(en1), .SCLK_i(sclk1),
      .tx_valid_i(valid1), .tx_data_i(data1), .tx_ready_o(ready1),
      .MOSI_o(mosi1), .tx_busy_o(busy1), .tx_done_o(done1), .underrun_o(under1)
   );

   always @(negedge clk) begin
      if (done0) dc0++;
      if (under0) uc0++;
      if (done1) dc1++;
      if (under1) uc1++;
      if (mon && !busy0) busy_low++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse0(input logic exp, input string tag);
      sclk0 = 1'b1;
      tick;
      tick;
      check(tag, 32'(mosi0), 32'(exp));
      sclk0 = 1'b0;
      tick;
      tick;
   endtask

   task automatic pulse1(input logic exp, input string tag);
      sclk1 = 1'b0;
      tick;
      tick;
      check(tag, 32'(mosi1), 32'(exp));
      sclk1 = 1'b1;
      tick;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      en0 = 1'b0; sclk0 = 1'b0; valid0 = 1'b0; data0 = 8'h00;
      en1 = 1'b0; sclk1 = 1'b1; valid1 = 1'b0; data1 = 8'h00;
      #12;
      check("rst_mosi0", 32'(mosi0), 32'd0);
      check("rst_ready0", 32'(ready0), 32'd1);
      check("rst_busy0", 32'(busy0), 32'd0);
      check("rst_done0", 32'(done0), 32'd0);
      check("rst_under0", 32'(under0), 32'd0);
      check("rst_ready1", 32'(ready1), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick;

      // underrun: enabled, no word, one pulse
      en0 = 1'b1;
      sclk0 = 1'b1;
      tick;
      check("under_pulse", 32'(under0), 32'd1);
      check("under_mosi", 32'(mosi0), 32'd0);
      tick;
      check("under_one_cycle", 32'(under0), 32'd0);
      sclk0 = 1'b0;
      tick;
      tick;
      check("under_count", 32'(uc0), 32'd1);

      // single word A5, CPOL0 CPHA0 MSB first
      w = 8'hA5;
      data0 = w; valid0 = 1'b1;
      tick;
      valid0 = 1'b0;
      check("a5_busy", 32'(busy0), 32'd1);
      check("a5_first_bit", 32'(mosi0), 32'd1);
`ifdef SPI_TX_DOUBLE_BUFFER_EN
      check("a5_ready", 32'(ready0), 32'd1);
`else
      check("a5_ready", 32'(ready0), 32'd0);
`endif
      for (int i = 0; i < 7; i++) pulse0(w[7-i], "a5_bit");
      sclk0 = 1'b1;
      tick;
      tick;
      check("a5_bit7", 32'(mosi0), 32'(w[0]));
      sclk0 = 1'b0;
      tick;
      check("a5_done", 32'(done0), 32'd1);
      check("a5_mosi_after", 32'(mosi0), 32'd0);
      check("a5_busy_after", 32'(busy0), 32'd0);
      tick;
      check("a5_done_width", 32'(done0), 32'd0);
      check("a5_done_count", 32'(dc0), 32'd1);

      // back-to-back A5 then 0F
      base = dc0;
      w = 8'hA5; w2 = 8'h0F;
      data0 = w; valid0 = 1'b1;
      tick;
      data0 = w2;
`ifdef SPI_TX_DOUBLE_BUFFER_EN
      tick;
      valid0 = 1'b0;
      check("b2b_hold_full", 32'(ready0), 32'd0);
`else
      check("b2b_stall", 32'(ready0), 32'd0);
`endif
      mon = 1'b1;
      for (int i = 0; i < 7; i++) pulse0(w[7-i], "b2b_w1_bit");
      sclk0 = 1'b1;
      tick;
      tick;
      check("b2b_w1_bit7", 32'(mosi0), 32'(w[0]));
      sclk0 = 1'b0;
      tick;
      check("b2b_w1_done", 32'(done0), 32'd1);
      tick;
      valid0 = 1'b0;
      check("b2b_w2_busy", 32'(busy0), 32'd1);
      for (int i = 0; i < 7; i++) pulse0(w2[7-i], "b2b_w2_bit");
      mon = 1'b0;
      sclk0 = 1'b1;
      tick;
      tick;
      check("b2b_w2_bit7", 32'(mosi0), 32'(w2[0]));
      sclk0 = 1'b0;
      tick;
      check("b2b_w2_done", 32'(done0), 32'd1);
      check("b2b_w2_idle", 32'(busy0), 32'd0);
      tick;
      check("b2b_done_count", 32'(dc0 - base), 32'd2);
`ifdef SPI_TX_DOUBLE_BUFFER_EN
      check("b2b_busy_gap", 32'(busy_low), 32'd0);
`else
      check("b2b_busy_gap", 32'(busy_low), 32'd1);
`endif

      // abort after three pulses of FF
      base = dc0;
      data0 = 8'hFF; valid0 = 1'b1;
      tick;
      valid0 = 1'b0;
      for (int i = 0; i < 3; i++) pulse0(1'b1, "abort_bit");
      en0 = 1'b0;
      tick;
      check("abort_busy", 32'(busy0), 32'd0);
      check("abort_mosi", 32'(mosi0), 32'd0);
      check("abort_ready", 32'(ready0), 32'd1);
      pulse0(1'b0, "abort_ignored");
      pulse0(1'b0, "abort_ignored");
      check("abort_no_done", 32'(dc0), 32'(base));
      check("abort_no_under", 32'(uc0), 32'd1);
      en0 = 1'b1;
      tick;

      // asynchronous reset mid-word
      data0 = 8'hFF; valid0 = 1'b1;
      tick;
      valid0 = 1'b0;
      for (int i = 0; i < 3; i++) pulse0(1'b1, "prerst_bit");
      check("prerst_mosi", 32'(mosi0), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_mosi", 32'(mosi0), 32'd0);
      check("arst_busy", 32'(busy0), 32'd0);
      check("arst_ready", 32'(ready0), 32'd1);
      check("arst_done", 32'(done0), 32'd0);
      tick;
      rst = 1'b0;
      tick;
      base = dc0;
      w = 8'h81;
      data0 = w; valid0 = 1'b1;
      tick;
      valid0 = 1'b0;
      check("w81_busy", 32'(busy0), 32'd1);
      for (int i = 0; i < 8; i++) pulse0(w[7-i], "w81_bit");
      check("w81_done_count", 32'(dc0 - base), 32'd1);
      check("w81_mosi_after", 32'(mosi0), 32'd0);
      check("w81_busy_after", 32'(busy0), 32'd0);

      // CPOL1 CPHA1 LSB first, 3C
      w = 8'h3C;
      data1 = w; en1 = 1'b1; valid1 = 1'b1;
      tick;
      valid1 = 1'b0;
      check("c3c_busy", 32'(busy1), 32'd1);
      check("c3c_mosi_load", 32'(mosi1), 32'd0);
      for (int i = 0; i < 8; i++) pulse1(w[i], "c3c_bit");
      check("c3c_done_count", 32'(dc1), 32'd1);
      check("c3c_mosi_after", 32'(mosi1), 32'd0);
      check("c3c_busy_after", 32'(busy1), 32'd0);
      check("c3c_no_under", 32'(uc1), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
